// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: sync detect, length-prefixed payload capture with
// additive checksum, buffered valid/ready drain, and single-cycle fault pulses.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 104_167
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  input  logic       i_ready,
  output logic [7:0] o_len,
  output logic       o_err_len,
  output logic       o_err_chksum,
  output logic       o_err_timeout,
  output logic       o_overrun,
  output logic [2:0] t_state
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHKSUM  = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [7:0]       r_len, w_len_nxt;
  logic [7:0]       r_sum, w_sum_nxt;
  logic [7:0]       r_olen, w_olen_nxt;
  logic [IDX_W-1:0] r_wr_idx, w_wr_idx_nxt;
  logic [IDX_W-1:0] r_rd_idx, w_rd_idx_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             r_err_len, w_err_len_nxt;
  logic             r_err_chk, w_err_chk_nxt;
  logic             r_err_tmo, w_err_tmo_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             w_buf_we;
  logic             w_in_frame;
  logic             w_tmo_hit;
  logic             w_len_bad;
  logic             w_wr_last;
  logic             w_rd_last;
  logic             w_draining;

  // Payload storage is deliberately left out of reset.
  logic [7:0] r_buf [MAX_LEN];

  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHKSUM);
  assign w_tmo_hit  = w_in_frame && !i_rx_valid && (r_tmo_cnt == TMO_LAST);
  assign w_len_bad  = (i_rx_data == 8'd0) || (i_rx_data > MAX_LEN_B);
  assign w_wr_last  = (8'(r_wr_idx) == (r_len - 8'd1));
  assign w_rd_last  = (8'(r_rd_idx) == (r_len - 8'd1));
  assign w_draining = (r_state == S_DRAIN);

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_sum_nxt     = r_sum;
    w_olen_nxt    = r_olen;
    w_wr_idx_nxt  = r_wr_idx;
    w_rd_idx_nxt  = r_rd_idx;
    w_buf_we      = 1'b0;
    w_err_len_nxt = 1'b0;
    w_err_chk_nxt = 1'b0;
    w_err_tmo_nxt = 1'b0;
    w_ovr_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
          w_state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        // A repeated sync byte here is a length value, not a resync.
        if (i_rx_valid) begin
          if (w_len_bad) begin
            w_err_len_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_len_nxt    = i_rx_data;
            w_sum_nxt    = i_rx_data;
            w_wr_idx_nxt = '0;
            w_state_nxt  = S_PAYLOAD;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (i_rx_valid) begin
          w_buf_we  = 1'b1;
          w_sum_nxt = r_sum + i_rx_data;
          if (w_wr_last) begin
            w_state_nxt = S_CHKSUM;
          end else begin
            w_wr_idx_nxt = r_wr_idx + 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_CHKSUM: begin
        if (i_rx_valid) begin
          if (i_rx_data == r_sum) begin
            w_rd_idx_nxt = '0;
            w_olen_nxt   = r_len;
            w_state_nxt  = S_DRAIN;
          end else begin
            w_err_chk_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The receiver cannot be stalled, so bytes landing here are lost.
        w_ovr_nxt = i_rx_valid;
        if (i_ready) begin
          w_rd_idx_nxt = r_rd_idx + 1'b1;
          if (w_rd_last) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_in_frame && !i_rx_valid && (w_state_nxt == r_state)) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
    end else begin
      w_tmo_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= 8'd0;
      r_sum     <= 8'd0;
      r_olen    <= 8'd0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_tmo_cnt <= '0;
      r_err_len <= 1'b0;
      r_err_chk <= 1'b0;
      r_err_tmo <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_sum     <= w_sum_nxt;
      r_olen    <= w_olen_nxt;
      r_wr_idx  <= w_wr_idx_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_err_len <= w_err_len_nxt;
      r_err_chk <= w_err_chk_nxt;
      r_err_tmo <= w_err_tmo_nxt;
      r_ovr     <= w_ovr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_wr_idx] <= i_rx_data;
    end
  end

  assign o_valid       = w_draining;
  assign o_data        = w_draining ? r_buf[r_rd_idx] : 8'd0;
  assign o_last        = w_draining && w_rd_last;
  assign o_len         = r_olen;
  assign o_err_len     = r_err_len;
  assign o_err_chksum  = r_err_chk;
  assign o_err_timeout = r_err_tmo;
  assign o_overrun     = r_ovr;
  assign t_state       = r_state;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frames are modelled as they are sent, expected payload
// bytes are queued and compared as the DUT drains them.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned TMO = 20;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_last;
  logic       i_ready;
  logic [7:0] o_len;
  logic       o_err_len;
  logic       o_err_chksum;
  logic       o_err_timeout;
  logic       o_overrun;
  logic [2:0] t_state;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE  (SYNC),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_last       (o_last),
    .i_ready      (i_ready),
    .o_len        (o_len),
    .o_err_len    (o_err_len),
    .o_err_chksum (o_err_chksum),
    .o_err_timeout(o_err_timeout),
    .o_overrun    (o_overrun),
    .t_state      (t_state)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int n_el = 0, n_ec = 0, n_et = 0, n_ov = 0, n_multi = 0;
  int x_el = 0, x_ec = 0, x_et = 0, x_ov = 0;
  logic [8:0] sb[$];
  logic [7:0] exp_len = 8'd0;
  logic [7:0] frm [0:31];
  int         frm_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: samples just after each falling edge, when inputs for the next rising edge are set.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      n_el += int'(o_err_len);
      n_ec += int'(o_err_chksum);
      n_et += int'(o_err_timeout);
      n_ov += int'(o_overrun);
      if ((int'(o_err_len) + int'(o_err_chksum) + int'(o_err_timeout) + int'(o_overrun)) > 1)
        n_multi++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(o_valid), 32'd0);
        end else begin
          check("o_data", 32'(o_data), 32'(sb[0][7:0]));
          check("o_last", 32'(o_last), 32'(sb[0][8]));
          check("o_len", 32'(o_len), 32'(exp_len));
          if (i_ready) void'(sb.pop_front());
        end
      end else begin
        check("idle_data_last", 32'({o_data, o_last}), 32'd0);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_tot);
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [7:0] b);
    frm[frm_n] = b;
    frm_n++;
  endtask

  function automatic logic [7:0] frm_sum(input int upto);
    logic [7:0] s = 8'd0;
    for (int i = 1; i < upto; i++) s = s + frm[i];
    return s;
  endfunction

  task automatic put_chk();
    put(frm_sum(frm_n));
  endtask

  function automatic bit frm_good();
    int len = int'(frm[1]);
    return (frm_n >= 4) && (frm[0] == SYNC) && (len != 0) && (len <= 16) &&
           (frm_n == len + 3) && (frm[frm_n-1] == frm_sum(frm_n - 1));
  endfunction

  task automatic push_frm();
    int len = int'(frm[1]);
    for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), frm[2+i]});
    exp_len = frm[1];
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'd0;
  endtask

  task automatic send_frm();
    if (frm_good()) push_frm();
    for (int i = 0; i < frm_n; i++) send_byte(frm[i]);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && (sb.size() != 0 || o_valid); k++) begin
      @(negedge clk);
      #2;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_len"}, 32'(n_el), 32'(x_el));
    check({tag, "_err_chk"}, 32'(n_ec), 32'(x_ec));
    check({tag, "_err_tmo"}, 32'(n_et), 32'(x_et));
    check({tag, "_overrun"}, 32'(n_ov), 32'(x_ov));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_data"}, 32'(o_data), 32'd0);
    check({tag, "_last"}, 32'(o_last), 32'd0);
    check({tag, "_len"}, 32'(o_len), 32'd0);
    check({tag, "_state"}, 32'(t_state), 32'd0);
    check({tag, "_pulses"}, 32'({o_err_len, o_err_chksum, o_err_timeout, o_overrun}), 32'd0);
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'd0;
    i_ready    = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;

    // Good 3-byte frame with ready held high: three consecutive beats.
    frm_n = 0; put(SYNC); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put_chk();
    send_frm();
    #2;
    check("a_beat0", 32'({o_valid, o_data, o_last}), 32'({1'b1, 8'h11, 1'b0}));
    @(negedge clk); #2;
    check("a_beat1", 32'({o_valid, o_data, o_last}), 32'({1'b1, 8'h22, 1'b0}));
    @(negedge clk); #2;
    check("a_beat2", 32'({o_valid, o_data, o_last}), 32'({1'b1, 8'h33, 1'b1}));
    @(negedge clk); #2;
    check("a_after_valid", 32'(o_valid), 32'd0);
    check("a_after_state", 32'(t_state), 32'd0);
    check("a_len_held", 32'(o_len), 32'd3);
    wait_drain();
    check_errs("a");

    // Same frame with a corrupted checksum, then a good frame.
    frm_n = 0; put(SYNC); put(8'h03); put(8'h11); put(8'h22); put(8'h33);
    put(frm_sum(5) + 8'd1);
    send_frm();
    x_ec++;
    repeat (3) @(negedge clk);
    check_errs("chk");
    frm_n = 0; put(SYNC); put(8'h02); put(8'hFE); put(8'h07); put_chk();
    send_frm();
    wait_drain();

    // Length boundaries: 0 and MAX_LEN+1 rejected, MAX_LEN accepted with checksum wrap.
    frm_n = 0; put(SYNC); put(8'h00);
    send_frm();
    x_el++;
    #2 check("len0_state", 32'(t_state), 32'd0);
    frm_n = 0; put(SYNC); put(8'h11);
    send_frm();
    x_el++;
    #2 check("len17_state", 32'(t_state), 32'd0);
    frm_n = 0; put(SYNC); put(8'd16);
    for (int i = 0; i < 16; i++) put(8'(i * 37 + 200));
    put_chk();
    send_frm();
    wait_drain();
    check_errs("len");

    // Inter-byte timeout latency.
    send_byte(SYNC); send_byte(8'h02); send_byte(8'h10);
    lat = 0;
    for (int k = 1; k <= int'(TMO) + 10 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (o_err_timeout) lat = k;
    end
    x_et++;
    check("tmo_latency", 32'(lat), 32'(TMO));
    @(negedge clk); #2;
    check("tmo_state", 32'(t_state), 32'd0);

    // A byte landing exactly on the expiry cycle wins.
    frm_n = 0; put(SYNC); put(8'h02); put(8'h10); put(8'h20); put_chk();
    push_frm();
    send_byte(frm[0]); send_byte(frm[1]); send_byte(frm[2]);
    repeat (TMO - 2) @(negedge clk);
    send_byte(frm[3]);
    send_byte(frm[4]);
    wait_drain();
    check_errs("tmo");

    // Backpressure for five cycles with a byte injected during the drain.
    frm_n = 0; put(SYNC); put(8'h04); put(8'h01); put(8'h02); put(8'h03); put(8'h04); put_chk();
    send_frm();
    @(negedge clk);
    i_ready    = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h55;
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    #2 check("hold_data", 32'({o_valid, o_data}), 32'({1'b1, 8'h02}));
    @(negedge clk);
    i_ready = 1'b1;
    x_ov++;
    wait_drain();
    check_errs("bp");

    // Reset mid-payload.
    send_byte(SYNC); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_payload");
    @(negedge clk);
    rst = 1'b0;
    frm_n = 0; put(SYNC); put(8'h01); put(8'h9C); put_chk();
    send_frm();
    wait_drain();

    // Reset mid-drain.
    i_ready = 1'b0;
    frm_n = 0; put(SYNC); put(8'h03); put(8'hAA); put(8'hBB); put(8'hCC); put_chk();
    send_frm();
    #2 check("pre_rst_valid", 32'(o_valid), 32'd1);
    rst = 1'b1;
    #1 check_all_zero("rst_drain");
    sb.delete();
    @(negedge clk);
    rst     = 1'b0;
    i_ready = 1'b1;
    frm_n = 0; put(SYNC); put(8'h02); put(8'h5A); put(8'hA5); put_chk();
    send_frm();
    wait_drain();

    repeat (3) @(negedge clk);
    check_errs("final");
    check("pulse_exclusive", 32'(n_multi), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
